relu_maxpool2d: RTL and testbench
=================================

RELU_MAXPOOL2D -- requirements
Module: relu_maxpool2d

Interface
REQ-001 Parameters:
- DATA_WIDTH, default 16: signed fixed-point sample width.
- CHANNELS, default 8: feature-map channels.
- IMG_SIZE, default 28: input height = width.
- POOL, default 2: pool window and stride.
- RELU, default 1: 1 = clamp negatives to 0, 0 = plain max-pool.
REQ-002 Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request to process the whole buffer.
- conv_addr  out  clog2(CHANNELS*IMG_SIZE^2)  conv-buffer read address.
- conv_en  out  1  conv-buffer read enable.
- conv_q  in  DATA_WIDTH  signed conv-buffer read data.
- pool_addr  out  clog2(CHANNELS*(IMG_SIZE/POOL)^2)  pool-buffer write address.
- pool_en  out  1  pool-buffer enable.
- pool_we  out  1  pool-buffer write enable.
- pool_d  out  DATA_WIDTH  signed pool-buffer write data.
- done  out  1  one-cycle completion pulse.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 All outputs SHALL be registered.
REQ-005 Elaboration SHALL fail if IMG_SIZE mod POOL != 0 or POOL < 1.

Function
REQ-006 Define OS = IMG_SIZE/POOL and N = CHANNELS*OS*OS output pixels.
REQ-007 FSM states: IDLE, READ, WAIT, CMP, WRITE, FINISH.
REQ-008 IDLE: if start=1, clear counters c, pr, pc, wr, wc, load the running max and go to READ; otherwise stay in IDLE.
REQ-009 Running max init value: 0 if RELU=1; -2^(DATA_WIDTH-1) if RELU=0.
REQ-010 READ: register conv_addr = (c*IMG_SIZE + pr*POOL + wr)*IMG_SIZE + pc*POOL + wc and conv_en=1 (one cycle), then go to WAIT.
REQ-011 WAIT: hold, then go to CMP; conv_q SHALL be sampled only in CMP (2-cycle registered BRAM latency).
REQ-012 CMP: running max <= signed max(running max, conv_q).
- If wc < POOL-1: wc++, go to READ.
- Else if wr < POOL-1: wc=0, wr++, go to READ.
- Else: go to WRITE.
REQ-013 WRITE: drive pool_addr = (c*OS + pr)*OS + pc, pool_d = running max, pool_en = pool_we = 1 for exactly one cycle.
- Reset wr, wc and reload the running max.
- Advance pc, then pr, then c (column fastest).
- Go to READ, or to FINISH after pixel N-1.
REQ-014 FINISH: done=1 for one cycle, then go to IDLE.
REQ-015 conv_en, pool_en, pool_we and done SHALL default to 0 every cycle unless asserted by the state above.
REQ-016 Cycle count: 3*POOL^2 + 1 cycles per output pixel. done SHALL be high in the cycle starting 13*N+2 edges after the edge that sampled start (POOL=2).
REQ-017 Comparisons SHALL be signed. No arithmetic widening: output equals one input sample or 0, so no saturation is needed.
REQ-018 start outside IDLE SHALL be ignored. start in the FINISH cycle SHALL be ignored. A new run needs start while in IDLE.
REQ-019 Each pool address SHALL be written exactly once per run, in ascending order 0..N-1.
REQ-020 Each input address SHALL be read at most once per run. Reads within a window are row-major.

Reset
REQ-021 While reset=1: state=IDLE, all counters 0, running max 0, and every output 0, including conv_addr, pool_addr and pool_d.
REQ-022 Reset asserted mid-run SHALL abort immediately with no further conv_en/pool_we pulses and no done pulse. After release, the block SHALL wait in IDLE for start.

Verification
REQ-023 CHANNELS=1, IMG_SIZE=4, RELU=1, input 0..15 row-major, one start -> pool writes addr 0..3 = 5, 7, 13, 15; done once, 54 edges after start.
REQ-024 RELU=1, all inputs -3 -> every pool_d = 0. Same stimulus with RELU=0 -> every pool_d = -3.
REQ-025 Window {-32768, 32767, 0, -1} -> pool_d = 32767. Window {-32768 x4} with RELU=0 -> pool_d = -32768.
REQ-026 Default params, random data vs reference model -> 1568 writes, exact match, addresses ascending; done at edge 20386; no conv_en or pool_we after done.
REQ-027 Assert reset 100 cycles after start -> next cycle all outputs 0; no done. Restart -> full correct result.
REQ-028 start pulsed every cycle during a run -> identical output and timing to a single start; exactly one done per run.

Source files
------------

// File: rtl/relu_maxpool2d.sv
// ReLU plus POOLxPOOL max-pooling engine that walks a conv feature buffer
// and writes one pooled sample per window into a pool buffer.
module relu_maxpool2d #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int IMG_SIZE   = 28,
  parameter int POOL       = 2,
  parameter int RELU       = 1,
  localparam int OS         = (POOL > 0) ? IMG_SIZE / POOL : 1,
  localparam int CONV_DEPTH = CHANNELS * IMG_SIZE * IMG_SIZE,
  localparam int POOL_DEPTH = CHANNELS * OS * OS,
  localparam int CONV_AW    = (CONV_DEPTH > 1) ? $clog2(CONV_DEPTH) : 1,
  localparam int POOL_AW    = (POOL_DEPTH > 1) ? $clog2(POOL_DEPTH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic [CONV_AW-1:0]           conv_addr,
  output logic                         conv_en,
  input  logic signed [DATA_WIDTH-1:0] conv_q,
  output logic [POOL_AW-1:0]           pool_addr,
  output logic                         pool_en,
  output logic                         pool_we,
  output logic signed [DATA_WIDTH-1:0] pool_d,
  output logic                         done
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OW = (OS > 1) ? $clog2(OS) : 1;
  localparam int PW = (POOL > 1) ? $clog2(POOL) : 1;

  localparam logic signed [DATA_WIDTH-1:0] MAX_INIT =
    (RELU != 0) ? '0 : {1'b1, {(DATA_WIDTH-1){1'b0}}};

  if (POOL < 1) begin : g_bad_pool
    $error("relu_maxpool2d: POOL must be at least 1");
  end else if (IMG_SIZE % POOL != 0) begin : g_bad_div
    $error("relu_maxpool2d: IMG_SIZE must be a multiple of POOL");
  end

  typedef enum logic [2:0] {IDLE, READ, WAIT, CMP, WRITE, FINISH} state_t;

  state_t state, state_next;

  logic [CW-1:0] c, c_next;
  logic [OW-1:0] pr, pr_next, pc, pc_next;
  logic [PW-1:0] wr, wr_next, wc, wc_next;
  logic signed [DATA_WIDTH-1:0] max_r, max_next;
  logic start_q;

  logic [CONV_AW-1:0] conv_addr_next;
  logic               conv_en_next;
  logic [POOL_AW-1:0] pool_addr_next;
  logic               pool_en_next, pool_we_next, done_next;
  logic signed [DATA_WIDTH-1:0] pool_d_next;

  // start is captured only while idle, so requests during a run or in FINISH vanish
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      c         <= '0;
      pr        <= '0;
      pc        <= '0;
      wr        <= '0;
      wc        <= '0;
      max_r     <= '0;
      conv_addr <= '0;
      conv_en   <= 1'b0;
      pool_addr <= '0;
      pool_en   <= 1'b0;
      pool_we   <= 1'b0;
      pool_d    <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      start_q   <= start && (state == IDLE);
      c         <= c_next;
      pr        <= pr_next;
      pc        <= pc_next;
      wr        <= wr_next;
      wc        <= wc_next;
      max_r     <= max_next;
      conv_addr <= conv_addr_next;
      conv_en   <= conv_en_next;
      pool_addr <= pool_addr_next;
      pool_en   <= pool_en_next;
      pool_we   <= pool_we_next;
      pool_d    <= pool_d_next;
      done      <= done_next;
    end
  end

  always_comb begin
    state_next     = state;
    c_next         = c;
    pr_next        = pr;
    pc_next        = pc;
    wr_next        = wr;
    wc_next        = wc;
    max_next       = max_r;
    conv_addr_next = conv_addr;
    conv_en_next   = 1'b0;
    pool_addr_next = pool_addr;
    pool_d_next    = pool_d;
    pool_en_next   = 1'b0;
    pool_we_next   = 1'b0;
    done_next      = 1'b0;

    case (state)
      IDLE: begin
        if (start_q) begin
          c_next     = '0;
          pr_next    = '0;
          pc_next    = '0;
          wr_next    = '0;
          wc_next    = '0;
          max_next   = MAX_INIT;
          state_next = READ;
        end
      end

      READ: begin
        conv_addr_next = CONV_AW'((32'(c) * 32'(IMG_SIZE) + 32'(pr) * 32'(POOL) + 32'(wr))
                                  * 32'(IMG_SIZE) + 32'(pc) * 32'(POOL) + 32'(wc));
        conv_en_next   = 1'b1;
        state_next     = WAIT;
      end

      WAIT: state_next = CMP;

      // conv_q is only valid here: two cycles after the read request was issued
      CMP: begin
        if (conv_q > max_r) max_next = conv_q;
        if (wc != PW'(POOL - 1)) begin
          wc_next    = wc + 1'b1;
          state_next = READ;
        end else if (wr != PW'(POOL - 1)) begin
          wc_next    = '0;
          wr_next    = wr + 1'b1;
          state_next = READ;
        end else begin
          state_next = WRITE;
        end
      end

      WRITE: begin
        pool_addr_next = POOL_AW'((32'(c) * 32'(OS) + 32'(pr)) * 32'(OS) + 32'(pc));
        pool_d_next    = max_r;
        pool_en_next   = 1'b1;
        pool_we_next   = 1'b1;
        wr_next        = '0;
        wc_next        = '0;
        max_next       = MAX_INIT;
        state_next     = READ;
        if (pc != OW'(OS - 1)) begin
          pc_next = pc + 1'b1;
        end else begin
          pc_next = '0;
          if (pr != OW'(OS - 1)) begin
            pr_next = pr + 1'b1;
          end else begin
            pr_next = '0;
            if (c != CW'(CHANNELS - 1)) c_next = c + 1'b1;
            else state_next = FINISH;
          end
        end
      end

      FINISH: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_relu_maxpool2d.sv
// Bench for relu_maxpool2d: a 4x4 table-driven pair (RELU on/off) and a
// default-size instance checked against a window-max reference model.
module tb_relu_maxpool2d;

  localparam int D_CH  = 8;
  localparam int D_IMG = 28;
  localparam int D_OS  = 14;
  localparam int D_N   = D_CH * D_OS * D_OS;
  localparam int D_IN  = D_CH * D_IMG * D_IMG;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // default-size instance
  logic start_d;
  logic [12:0] conv_addr_d;
  logic conv_en_d;
  logic signed [15:0] conv_q_d;
  logic [10:0] pool_addr_d;
  logic pool_en_d, pool_we_d, done_d;
  logic signed [15:0] pool_d_d;

  // 4x4 single-channel instances, one with ReLU and one plain
  logic start_s;
  logic [3:0] conv_addr_r, conv_addr_p;
  logic conv_en_r, conv_en_p;
  logic signed [15:0] conv_q_r, conv_q_p;
  logic [1:0] pool_addr_r, pool_addr_p;
  logic pool_en_r, pool_en_p, pool_we_r, pool_we_p, done_r, done_p;
  logic signed [15:0] pool_d_r, pool_d_p;

  relu_maxpool2d dut (
    .clk(clk), .reset(reset), .start(start_d),
    .conv_addr(conv_addr_d), .conv_en(conv_en_d), .conv_q(conv_q_d),
    .pool_addr(pool_addr_d), .pool_en(pool_en_d), .pool_we(pool_we_d),
    .pool_d(pool_d_d), .done(done_d)
  );

  relu_maxpool2d #(.CHANNELS(1), .IMG_SIZE(4), .POOL(2), .RELU(1)) dut_r (
    .clk(clk), .reset(reset), .start(start_s),
    .conv_addr(conv_addr_r), .conv_en(conv_en_r), .conv_q(conv_q_r),
    .pool_addr(pool_addr_r), .pool_en(pool_en_r), .pool_we(pool_we_r),
    .pool_d(pool_d_r), .done(done_r)
  );

  relu_maxpool2d #(.CHANNELS(1), .IMG_SIZE(4), .POOL(2), .RELU(0)) dut_p (
    .clk(clk), .reset(reset), .start(start_s),
    .conv_addr(conv_addr_p), .conv_en(conv_en_p), .conv_q(conv_q_p),
    .pool_addr(pool_addr_p), .pool_en(pool_en_p), .pool_we(pool_we_p),
    .pool_d(pool_d_p), .done(done_p)
  );

  logic signed [15:0] mem_d [D_IN];
  logic signed [15:0] mem_s [16];

  // one-register read port; together with the DUT's registered request this is the 2-cycle latency
  always @(posedge clk) begin
    if (conv_en_d) conv_q_d <= mem_d[conv_addr_d];
    if (conv_en_r) conv_q_r <= mem_s[conv_addr_r];
    if (conv_en_p) conv_q_p <= mem_s[conv_addr_p];
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int failures = 0;

  logic [10:0] wa_d[$];
  logic signed [15:0] wd_d[$];
  bit rd_seen_d [D_IN];
  int reads_d, dup_reads_d, done_cnt_d, done_edge_d, after_done_d, en_bad_d;

  logic [1:0] wa_r[$], wa_p[$];
  logic signed [15:0] wd_r[$], wd_p[$];
  int done_cnt_r, done_edge_r, done_cnt_p, done_edge_p;

  always @(negedge clk) begin
    if (done_cnt_d > 0 && (conv_en_d || pool_we_d)) after_done_d++;
    if (pool_we_d) begin
      wa_d.push_back(pool_addr_d);
      wd_d.push_back(pool_d_d);
      if (!pool_en_d) en_bad_d++;
    end
    if (conv_en_d) begin
      reads_d++;
      if (rd_seen_d[conv_addr_d]) dup_reads_d++;
      rd_seen_d[conv_addr_d] = 1'b1;
    end
    if (done_d) begin
      done_cnt_d++;
      done_edge_d = edge_cnt;
    end
    if (pool_we_r) begin wa_r.push_back(pool_addr_r); wd_r.push_back(pool_d_r); end
    if (pool_we_p) begin wa_p.push_back(pool_addr_p); wd_p.push_back(pool_d_p); end
    if (done_r) begin done_cnt_r++; done_edge_r = edge_cnt; end
    if (done_p) begin done_cnt_p++; done_edge_p = edge_cnt; end
  end

  typedef struct {
    logic signed [15:0] vals [16];
    logic signed [15:0] exp_relu [4];
    logic signed [15:0] exp_plain [4];
  } vec_t;

  vec_t vecs [4];

  task automatic check_output(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic fill_table();
    int vals_tab [4][16] = '{
      '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
      '{-3, -3, -3, -3, -3, -3, -3, -3, -3, -3, -3, -3, -3, -3, -3, -3},
      '{-32768, 32767, -32768, -32768, 0, -1, -32768, -32768,
        -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768},
      '{-5, -9, 2, -1, -7, -2, -8, -3, 10, -4, -6, -6, 0, 3, -20, -1}
    };
    int relu_tab [4][4] = '{'{5, 7, 13, 15}, '{0, 0, 0, 0},
                            '{32767, 0, 0, 0}, '{0, 2, 10, 0}};
    int plain_tab [4][4] = '{'{5, 7, 13, 15}, '{-3, -3, -3, -3},
                             '{32767, -32768, -32768, -32768}, '{-2, 2, 10, -1}};
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 16; i++) vecs[v].vals[i] = 16'(vals_tab[v][i]);
      for (int i = 0; i < 4; i++) begin
        vecs[v].exp_relu[i]  = 16'(relu_tab[v][i]);
        vecs[v].exp_plain[i] = 16'(plain_tab[v][i]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_conv_addr"}, conv_addr_d, 0);
    check_output({tag, "_conv_en"}, conv_en_d, 0);
    check_output({tag, "_pool_addr"}, pool_addr_d, 0);
    check_output({tag, "_pool_en"}, pool_en_d, 0);
    check_output({tag, "_pool_we"}, pool_we_d, 0);
    check_output({tag, "_pool_d"}, pool_d_d, 0);
    check_output({tag, "_done"}, done_d, 0);
    check_output({tag, "_small_outs"}, {conv_addr_r, conv_en_r, pool_addr_r, pool_en_r,
                                        pool_we_r, pool_d_r, done_r}, 0);
  endtask

  task automatic apply_stimulus_small(input int v, input bit hold_start);
    int start_edge, n;
    string tag;
    tag = $sformatf("v%0d%s", v, hold_start ? "_hold" : "");
    mem_s = vecs[v].vals;
    wa_r.delete(); wd_r.delete(); wa_p.delete(); wd_p.delete();
    done_cnt_r = 0; done_cnt_p = 0; done_edge_r = 0; done_edge_p = 0;
    start_edge = edge_cnt + 1;
    start_s = 1'b1;
    n = 0;
    while (done_cnt_r == 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (!hold_start || (edge_cnt - start_edge) >= 48) start_s = 1'b0;
    end
    start_s = 1'b0;
    check_output({tag, "_done_seen"}, done_cnt_r > 0, 1);
    repeat (15) @(negedge clk);
    check_output({tag, "_done_edge_relu"}, done_edge_r - start_edge, 54);
    check_output({tag, "_done_edge_plain"}, done_edge_p - start_edge, 54);
    check_output({tag, "_done_count"}, done_cnt_r + 10 * done_cnt_p, 11);
    check_output({tag, "_writes_relu"}, wa_r.size(), 4);
    check_output({tag, "_writes_plain"}, wa_p.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wa_r.size()) begin
        check_output($sformatf("%s_addr_relu%0d", tag, i), wa_r[i], i);
        check_output($sformatf("%s_data_relu%0d", tag, i), wd_r[i], vecs[v].exp_relu[i]);
      end
      if (i < wa_p.size()) begin
        check_output($sformatf("%s_addr_plain%0d", tag, i), wa_p[i], i);
        check_output($sformatf("%s_data_plain%0d", tag, i), wd_p[i], vecs[v].exp_plain[i]);
      end
    end
  endtask

  task automatic clear_default_monitor();
    wa_d.delete(); wd_d.delete();
    for (int i = 0; i < D_IN; i++) rd_seen_d[i] = 1'b0;
    reads_d = 0; dup_reads_d = 0; done_cnt_d = 0; done_edge_d = 0;
    after_done_d = 0; en_bad_d = 0;
  endtask

  task automatic randomize_image();
    for (int i = 0; i < D_IN; i++) mem_d[i] = 16'($urandom);
  endtask

  task automatic apply_stimulus_default(input string tag);
    logic signed [15:0] expv [D_N];
    logic signed [15:0] m;
    int start_edge, n, bad_addr, bad_data, first_bad;
    // reference: plain window maximum over the image, then clamp negatives
    for (int c = 0; c < D_CH; c++)
      for (int oy = 0; oy < D_OS; oy++)
        for (int ox = 0; ox < D_OS; ox++) begin
          m = mem_d[c * D_IMG * D_IMG + (2 * oy) * D_IMG + 2 * ox];
          for (int y = 2 * oy; y < 2 * oy + 2; y++)
            for (int x = 2 * ox; x < 2 * ox + 2; x++)
              if (mem_d[c * D_IMG * D_IMG + y * D_IMG + x] > m)
                m = mem_d[c * D_IMG * D_IMG + y * D_IMG + x];
          if (m < 0) m = 0;
          expv[(c * D_OS + oy) * D_OS + ox] = m;
        end
    clear_default_monitor();
    start_edge = edge_cnt + 1;
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    n = 0;
    while (done_cnt_d == 0 && n < 21000) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_done_seen"}, done_cnt_d > 0, 1);
    repeat (20) @(negedge clk);
    check_output({tag, "_done_edge"}, done_edge_d - start_edge, 13 * D_N + 2);
    check_output({tag, "_done_count"}, done_cnt_d, 1);
    check_output({tag, "_activity_after_done"}, after_done_d, 0);
    check_output({tag, "_writes"}, wa_d.size(), D_N);
    check_output({tag, "_reads"}, reads_d, 4 * D_N);
    check_output({tag, "_dup_reads"}, dup_reads_d, 0);
    check_output({tag, "_we_without_en"}, en_bad_d, 0);
    bad_addr = 0; bad_data = 0; first_bad = -1;
    for (int i = 0; i < wa_d.size() && i < D_N; i++) begin
      if (int'(wa_d[i]) != i) bad_addr++;
      if (wd_d[i] != expv[i]) begin
        bad_data++;
        if (first_bad < 0) first_bad = i;
      end
    end
    check_output({tag, "_addr_order_errors"}, bad_addr, 0);
    check_output({tag, "_data_errors"}, bad_data, 0);
    if (first_bad >= 0)
      check_output($sformatf("%s_first_bad_pixel%0d", tag, first_bad), wd_d[first_bad], expv[first_bad]);
  endtask

  task automatic apply_stimulus_reset_abort();
    int reads_at, writes_at;
    randomize_image();
    clear_default_monitor();
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    reads_at = reads_d;
    writes_at = wa_d.size();
    repeat (40) @(negedge clk);
    check_output("abort_reads_after_release", reads_d - reads_at, 0);
    check_output("abort_writes_after_release", wa_d.size() - writes_at, 0);
    check_output("abort_no_done", done_cnt_d, 0);
    randomize_image();
    apply_stimulus_default("restart");
  endtask

  initial begin
    reset = 1'b1;
    start_d = 1'b0;
    start_s = 1'b0;
    fill_table();
    clear_default_monitor();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) apply_stimulus_small(v, 1'b0);
    apply_stimulus_small(0, 1'b1);
    apply_stimulus_small(3, 1'b1);

    randomize_image();
    apply_stimulus_default("default");
    apply_stimulus_reset_abort();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
